// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: multi-cycle MULTU/DIVU sequencer driving HI/LO, with MTHI/MTLO writes.
// Optional MULDIV_EARLY_OUT_EN finishes MULTU as soon as the remaining multiplier is zero.
module mips_muldiv_seq #(
  parameter int          WIDTH    = 32,
  parameter logic [3:0]  OP_MULTU = 4'd3,
  parameter logic [3:0]  OP_DIVU  = 4'd4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [3:0]       AluOP,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             cancel,
  input  logic             mt_hi,
  input  logic             mt_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opa_q, opa_d, mpl_q, mpl_d, hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, mul_res, div_next;
  logic [WIDTH-1:0]   mpl_next;
  logic               last, mul_fin;
  // acc holds the product in MUL and {rem,quo} in DIV; opa holds multiplicand or divisor
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mpl_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign mpl_next  = mpl_q >> 1;
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opa_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign last      = cnt_q == CW'(WIDTH-1);
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_fin   = last || (mpl_next == '0);
  assign mul_res   = mul_next >> (CW'(WIDTH-1) - cnt_q);
`else
  assign mul_fin   = last;
  assign mul_res   = mul_next;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    mpl_d   = mpl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        hi_d    = mt_hi ? wdata : hi_q;
        lo_d    = mt_lo ? wdata : lo_q;
        state_d = S_IDLE;
        // a result from this same edge overrides a simultaneous move-to
        if (state_q == S_IDLE && start) begin
          if (AluOP == OP_MULTU) begin
            opa_d   = X;
            mpl_d   = Y;
            acc_d   = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = S_MUL;
          end else if (AluOP == OP_DIVU && Y != '0) begin
            opa_d   = Y;
            acc_d   = {{WIDTH{1'b0}}, X};
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = S_DIV;
          end else if (AluOP == OP_DIVU) begin
            hi_d    = X;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d   = mul_next;
        mpl_d   = mpl_next;
        cnt_d   = cnt_q + CW'(1);
        hi_d    = mul_fin ? mul_res[2*WIDTH-1:WIDTH] : hi_q;
        lo_d    = mul_fin ? mul_res[WIDTH-1:0] : lo_q;
        state_d = mul_fin ? S_DONE : S_MUL;
        if (cancel) begin
          hi_d    = hi_q;
          lo_d    = lo_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        acc_d   = div_next;
        cnt_d   = cnt_q + CW'(1);
        hi_d    = (last && !cancel) ? div_next[2*WIDTH-1:WIDTH] : hi_q;
        lo_d    = (last && !cancel) ? div_next[WIDTH-1:0] : lo_q;
        state_d = cancel ? S_IDLE : (last ? S_DONE : S_DIV);
      end
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      mpl_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      mpl_q   <= mpl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = state_q == S_DONE;
  assign div_zero = dz_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb_mips_muldiv_seq: directed vectors for the MULTU/DIVU sequencer, hand-computed results.
module tb_mips_muldiv_seq;
  localparam logic [3:0] OP_MULTU = 4'd3, OP_DIVU = 4'd4;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int          LAT_SHORT = 2;
  localparam logic [31:0] Y_CANCEL  = 32'h8000_0005;
`else
  localparam int          LAT_SHORT = 33;
  localparam logic [31:0] Y_CANCEL  = 32'h0000_0005;
`endif
  logic        CLK = 1'b0, RESET_N = 1'b0, start = 1'b0, cancel = 1'b0, mt_hi = 1'b0, mt_lo = 1'b0;
  logic [3:0]  AluOP = '0;
  logic [31:0] X = '0, Y = '0, wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] HI, LO;
  int n_vec = 0, n_err = 0;
  int cyc, bc, dc;
  mips_muldiv_seq dut (
    .CLK(CLK), .RESET_N(RESET_N), .start(start), .AluOP(AluOP), .X(X), .Y(Y),
    .cancel(cancel), .mt_hi(mt_hi), .mt_lo(mt_lo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    AluOP = op;
    X     = x;
    Y     = y;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  // cycle number in which done appears (1 = cycle after the start edge) and busy cycles seen
  task automatic wait_done(output int c, output int b);
    c = 1;
    b = 0;
    while (!done && c < 200) begin
      b += int'(busy);
      tick;
      c++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dz", 32'(div_zero), 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    tick;
    RESET_N = 1'b1;
    tick;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    chk("mulmax_lat", 32'(cyc), 33);
    chk("mulmax_busy", 32'(bc), 32);
    chk("mulmax_hi", HI, 32'hFFFF_FFFE);
    chk("mulmax_lo", LO, 32'h0000_0001);
    tick;
    chk("done_pulse", 32'(done), 0);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc, bc);
    chk("div_lat", 32'(cyc), 33);
    chk("div_lo", LO, 32'd14);
    chk("div_hi", HI, 32'd2);
    chk("div_dz", 32'(div_zero), 0);
    tick;
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_done(cyc, bc);
    chk("dz_lat", 32'(cyc), 1);
    chk("dz_busy", 32'(bc), 0);
    chk("dz_hi", HI, 32'd5);
    chk("dz_lo", LO, 32'hFFFF_FFFF);
    chk("dz_flag", 32'(div_zero), 1);
    tick;
    issue(OP_MULTU, 32'd3, Y_CANCEL);
    for (int c = 1; c < 12; c++) begin
      start = (c == 5);
      AluOP = OP_DIVU;
      X     = 32'd100;
      Y     = 32'd7;
      tick;
    end
    start = 1'b0;
    chk("cancel_busy_pre", 32'(busy), 1);
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 0);
    chk("cancel_done", 32'(done), 0);
    chk("cancel_hi", HI, 32'd5);
    chk("cancel_lo", LO, 32'hFFFF_FFFF);
    chk("cancel_dz", 32'(div_zero), 0);
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      dc += int'(done) + int'(busy);
      tick;
    end
    chk("cancel_quiet", 32'(dc), 0);
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_done(cyc, bc);
    chk("mul35_hi", HI, 32'd0);
    chk("mul35_lo", LO, 32'd15);
    start = 1'b1;
    AluOP = OP_DIVU;
    tick;
    start = 1'b0;
    chk("start_in_done_busy", 32'(busy), 0);
    chk("start_in_done_done", 32'(done), 0);
    issue(OP_MULTU, 32'h10, 32'h10);
    tick;
    mt_hi = 1'b1;
    wdata = 32'hDEAD_BEEF;
    tick;
    mt_hi = 1'b0;
    wait_done(cyc, bc);
    chk("mt_busy_hi", HI, 32'd0);
    chk("mt_busy_lo", LO, 32'h100);
    tick;
    mt_hi = 1'b1;
    tick;
    mt_hi = 1'b0;
    chk("mt_idle_hi", HI, 32'hDEAD_BEEF);
    chk("mt_idle_lo", LO, 32'h100);
    issue(OP_MULTU, 32'd2, 32'd3);
    wait_done(cyc, bc);
    chk("mul23_lo", LO, 32'd6);
    mt_lo = 1'b1;
    wdata = 32'h0000_CAFE;
    tick;
    mt_lo = 1'b0;
    chk("mt_done_lo", LO, 32'h0000_CAFE);
    chk("mt_done_hi", HI, 32'd0);
    mt_hi = 1'b1;
    wdata = 32'h1111;
    issue(OP_MULTU, 32'd7, 32'd9);
    mt_hi = 1'b0;
    chk("mt_start_hi", HI, 32'h1111);
    wait_done(cyc, bc);
    chk("mt_start_res_hi", HI, 32'd0);
    chk("mt_start_res_lo", LO, 32'd63);
    tick;
    issue(OP_MULTU, 32'h1234, 32'd1);
    wait_done(cyc, bc);
    chk("mul1_lat", 32'(cyc), 32'(LAT_SHORT));
    chk("mul1_hi", HI, 32'd0);
    chk("mul1_lo", LO, 32'h1234);
    tick;
    issue(OP_MULTU, 32'hABCD, 32'd0);
    wait_done(cyc, bc);
    chk("mul0_lat", 32'(cyc), 32'(LAT_SHORT));
    chk("mul0_lo", LO, 32'd0);
    tick;
    mt_hi = 1'b1;
    mt_lo = 1'b1;
    wdata = 32'hAAAA_5555;
    tick;
    mt_hi = 1'b0;
    mt_lo = 1'b0;
    chk("mt_both_hi", HI, 32'hAAAA_5555);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int c = 1; c < 10; c++) tick;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    chk("arst_done", 32'(done), 0);
    tick;
    RESET_N = 1'b1;
    tick;
    chk("arst_idle", 32'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mips_muldiv_seq.md
Name: mips_muldiv_seq

Overview:
- Multi-cycle sequencer for the MULTU/DIVU ALU operations (AluOP 3/4); the combinational ALU returns 0 for these codes.
- Accepts a start request from the decode/execute stage, runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, and writes the HI/LO result registers.
- Also services move-to-HI/LO writes.
- Sits beside the ALU in the execute stage; the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand width and number of iterations.
- OP_MULTU, 3, AluOP code selecting unsigned multiply.
- OP_DIVU, 4, AluOP code selecting unsigned divide.

Ports:
- CLK  input  1  single system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- AluOP  input  4  operation code, sampled with start.
- X  input  WIDTH  multiplicand / dividend.
- Y  input  WIDTH  multiplier / divisor.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- mt_hi  input  1  write wdata to HI (MTHI).
- mt_lo  input  1  write wdata to LO (MTLO).
- wdata  input  WIDTH  move-to data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO hold a new result.
- div_zero  output  1  sticky flag; set by DIVU with Y==0, cleared by the next accepted start.
- HI  output  WIDTH  high product / remainder.
- LO  output  WIDTH  low product / quotient.

Behaviour:
- Reset (async, RESET_N=0): state=IDLE; busy=0, done=0, div_zero=0, HI=0, LO=0; iteration counter=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE + start + AluOP==OP_MULTU: latch X, Y; acc=0; cnt=0; go to MUL.
- IDLE + start + AluOP==OP_DIVU, Y!=0: latch operands; rem=0; quo=X; go to DIV.
- IDLE + start + AluOP==OP_DIVU, Y==0: no iterations. Next edge writes HI=X, LO={WIDTH{1}}, sets div_zero, goes to DONE (done visible 1 cycle after start).
- start with any other AluOP: ignored; stay IDLE.
- MUL iteration, one per edge: if multiplier LSB=1, add multiplicand into upper half of 2*WIDTH accumulator (WIDTH+1-bit add, carry kept); shift accumulator and multiplier right 1; cnt++.
- DIV iteration, one per edge: shift {rem,quo} left 1; trial = rem - Y (WIDTH+1 bits); if non-negative, rem=trial and quo LSB=1; cnt++.
- On the edge completing iteration WIDTH-1, write HI/LO and go to DONE.
  - MUL: HI=acc[2W-1:W], LO=acc[W-1:0].
  - DIV: HI=rem, LO=quo.
- Latency: start sampled at edge 0; done high during the cycle after edge WIDTH (32 for default). HI/LO are valid in that same cycle.
- busy: high from the edge after start until the state leaves MUL/DIV. It is low in DONE and IDLE.
- DONE: done=1 for exactly one cycle, then IDLE. A start arriving during DONE is ignored.
- start while busy: ignored, no queuing.
- cancel in MUL/DIV: next edge returns to IDLE. HI/LO are unchanged, no done, div_zero unchanged. cancel in IDLE/DONE has no effect.
- mt_hi/mt_lo:
  - Honoured in IDLE and DONE; ignored while busy.
  - In DONE, the move-to wins over the result already written (it is written on the following edge).
  - Simultaneous start and mt in IDLE: both take effect; the later result overwrites HI/LO.
- All arithmetic is unsigned modulo 2^(2*WIDTH). No overflow flags.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in MUL, when the remaining (shifted) multiplier is zero, finish immediately. Shift the accumulator right by the remaining count in one step, write HI/LO, go to DONE.
  - MULTU with Y==0 completes with done 2 cycles after start.
  - DIV timing is unchanged.
- Not defined: MUL always takes exactly WIDTH iterations.
- Results are identical either way.

Test Plan:
- Reset mid-MUL: RESET_N low at iteration 10 -> HI=LO=0, busy=0, state IDLE immediately (async).
- MULTU X=0xFFFFFFFF, Y=0xFFFFFFFF -> done in cycle 33 after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for 32 cycles.
- DIVU X=100, Y=7 -> done at cycle 33; LO=14, HI=2, div_zero=0. Then DIVU X=5, Y=0 -> done at cycle 1; HI=5, LO=0xFFFFFFFF, div_zero=1.
- MULTU X=3, Y=5, cancel at cycle 12 -> no done; HI/LO keep prior values. A second start while busy is ignored.
- mt_hi wdata=0xDEADBEEF while busy -> ignored. Repeat in IDLE -> HI=0xDEADBEEF next cycle; LO untouched.
- MULDIV_EARLY_OUT_EN on: MULTU X=0x1234, Y=1 -> done at cycle 2; LO=0x1234, HI=0. Same results with the macro off at cycle 33.
